fifo_uart_tx: RTL and testbench

Read-side consumer of the byte FIFO. Drains bytes from the FIFO read port in the read clock domain and serialises each byte as an 8N1 UART frame on txd. It replaces the simple debug reader on the FIFO's read end and is the transmit half of the serial link.

---
 rtl/fifo_uart_tx.sv | 136 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the show-ahead byte FIFO and sends each byte as 8N1.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1).
module fifo_uart_tx #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       rd_empty,
  input  logic [7:0] rd_data,
  output logic       rd_req,
  output logic       txd,
  output logic       busy,
  output logic       tx_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(BAUD_DIV - 2);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  assign bit_end = (baud_cnt == LAST);

  // Pulled in the IDLE cycle so the show-ahead data is captured at its edge.
  assign rd_req = rst_n & (state == IDLE) & tx_en & ~rd_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      txd       <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (rd_req) begin
            shift_reg <= rd_data;
            baud_cnt  <= '0;
            state     <= START;
            txd       <= 1'b0;
            busy      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par       <= ^rd_data;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            txd      <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              txd   <= par;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              txd <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= STOP;
            txd      <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          // Look one clock ahead so the pulse lands on the last stop clock.
          tx_done <= (baud_cnt == PRE);
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx at BAUD_DIV=10.
// A small show-ahead FIFO model feeds the transmitter.
module tb_fifo_uart_tx;

  localparam int BD = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * BD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b0;
  logic       rd_empty;
  logic [7:0] rd_data;
  logic       rd_req;
  logic       txd;
  logic       busy;
  logic       tx_done;

  logic [7:0] mem [16];
  int head = 0;
  int tail = 0;
  int cyc = 0;
  int nreq = 0;
  int req_t[$];
  int ncmp = 0;
  int nbad = 0;

  assign rd_empty = (head == tail);
  assign rd_data  = mem[head[3:0]];

  fifo_uart_tx #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_en   (tx_en),
    .rd_empty(rd_empty),
    .rd_data (rd_data),
    .rd_req  (rd_req),
    .txd     (txd),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_req) begin
      head <= head + 1;
      nreq <= nreq + 1;
      req_t.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[tail[3:0]] = b;
    tail++;
  endtask

  task automatic wait_req(input string tag);
    int i = 0;
    #1;
    while (rd_req !== 1'b1 && i < 300) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk(tag, {31'd0, rd_req}, 1);
  endtask

  // Called in the rd_req cycle; walks the whole frame and the idle clock after.
  task automatic check_frame(input string tag, input logic [7:0] b,
                             input int off_at);
    int bad = 0;
    logic e;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      #1;
      if (k == off_at) tx_en = 1'b0;
      if (k < BD) e = 1'b0;
      else if (k < 9 * BD) e = b[k / BD - 1];
      else if (k < 10 * BD && NB == 11) e = ^b;
      else e = 1'b1;
      if (txd !== e) bad++;
      if (tx_done !== (k == FL - 1)) bad++;
      if (busy !== 1'b1) bad++;
      if (rd_req !== 1'b0) bad++;
    end
    chk({tag, "_bits"}, bad, 0);
    @(negedge clk);
    #1;
    chk({tag, "_idle"}, {29'd0, busy, tx_done, txd}, 3'b001);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0;
    tx_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out", {28'd0, txd, busy, tx_done, rd_req}, 4'b1000);
    rst_n = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      #1;
      if ({txd, busy, tx_done, rd_req} !== 4'b1000) bad++;
    end
    chk("idle200", bad, 0);
    chk("nreq0", nreq, 0);

    push(8'hA5);
    wait_req("req_a5");
    check_frame("a5", 8'hA5, -1);
    chk("no_req_a5", {31'd0, rd_req}, 0);
    chk("nreq1", nreq, 1);

    push(8'h55);
    push(8'h0F);
    wait_req("req_55");
    check_frame("f55", 8'h55, -1);
    chk("b2b_req", {31'd0, rd_req}, 1);
    check_frame("f0f", 8'h0F, -1);
    chk("gap", req_t[2] - req_t[1], FL + 1);
    chk("nreq3", nreq, 3);

    push(8'h3C);
    push(8'h81);
    wait_req("req_3c");
    check_frame("f3c", 8'h3C, 30);
    bad = 0;
    repeat (20) begin
      if (rd_req !== 1'b0) bad++;
      @(negedge clk);
      #1;
    end
    chk("hold", bad, 0);
    chk("nreq4", nreq, 4);
    tx_en = 1'b1;
    #1;
    chk("resume", {31'd0, rd_req}, 1);
    check_frame("f81", 8'h81, -1);

    push(8'h12);
    push(8'h34);
    wait_req("req_12");
    repeat (45) @(negedge clk);
    #1;
    chk("mid_bit3", {31'd0, txd}, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {30'd0, txd, busy}, 2'b10);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_req("req_34");
    check_frame("f34", 8'h34, -1);
    chk("nreq7", nreq, 7);

`ifdef UART_TX_PARITY_EN
    push(8'h07);
    push(8'h07);
    wait_req("req_07");
    check_frame("f07a", 8'h07, -1);
    chk("b2b_par", {31'd0, rd_req}, 1);
    check_frame("f07b", 8'h07, -1);
    chk("gap_par", req_t[8] - req_t[7], FL + 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
